// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared types and defaults for the register-bank writeback arbiter.
package rf_writeback_arbiter_pkg;

   localparam int DATA_W_DEF     = 32;
   localparam int ADDR_W_DEF     = 5;
   localparam int LINK_REG_DEF   = 31;
   localparam int DROP_CNT_W_DEF = 8;

   typedef enum logic {
      PREFER_ALU = 1'b0,
      PREFER_MEM = 1'b1
   } rr_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_LINK = 2'd1,
      GNT_ALU  = 2'd2,
      GNT_MEM  = 2'd3
   } grant_t;

   // Round-robin advances only on ALU/mem grants; link or idle leave it alone.
   function automatic rr_state_t rr_next(input rr_state_t cur, input grant_t gnt);
      rr_state_t nxt;
      case (gnt)
         GNT_ALU: nxt = PREFER_MEM;
         GNT_MEM: nxt = PREFER_ALU;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Writeback requester, bank write port and decode hazard signals of the arbiter.
interface rf_writeback_arbiter_if
   import rf_writeback_arbiter_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DROP_CNT_W = DROP_CNT_W_DEF
) ();

   logic                  link_valid;
   logic [DATA_W-1:0]     link_pc;
   logic                  link_ready;
   logic                  alu_valid;
   logic [ADDR_W-1:0]     alu_addr;
   logic [DATA_W-1:0]     alu_data;
   logic                  alu_ready;
   logic                  mem_valid;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_data;
   logic                  mem_ready;
   logic                  rf_we;
   logic [ADDR_W-1:0]     rf_waddr;
   logic [DATA_W-1:0]     rf_wdata;
   logic [ADDR_W-1:0]     rd_addr_a;
   logic [ADDR_W-1:0]     rd_addr_b;
   logic                  hazard_a;
   logic                  hazard_b;
   logic [DROP_CNT_W-1:0] drop_count;

   modport master (
      output link_valid, link_pc, alu_valid, alu_addr, alu_data,
             mem_valid, mem_addr, mem_data, rd_addr_a, rd_addr_b,
      input  link_ready, alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata,
             hazard_a, hazard_b, drop_count
   );

   modport slave (
      input  link_valid, link_pc, alu_valid, alu_addr, alu_data,
             mem_valid, mem_addr, mem_data, rd_addr_a, rd_addr_b,
      output link_ready, alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata,
             hazard_a, hazard_b, drop_count
   );

endinterface

// File: rtl/rf_writeback_arbiter_hazard_check.sv
// Read-after-write detector for one decode read port against all in-flight writes.
module rf_hazard_check
   import rf_writeback_arbiter_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int LINK_REG = LINK_REG_DEF
) (
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic              link_valid,
   output logic              hazard
);

   localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

   logic hit_s;

   // Register 0 is hardwired, so reading it never waits on a write.
   always_comb begin
      hit_s  = (wb_valid   && (rd_addr == wb_addr))   ||
               (alu_valid  && (rd_addr == alu_addr))  ||
               (mem_valid  && (rd_addr == mem_addr))  ||
               (link_valid && (rd_addr == LINK_ADDR));
      hazard = (rd_addr != ZERO_ADDR) && hit_s;
   end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Arbitrates link/ALU/load writebacks onto the single register-bank write port
// and flags read-after-write hazards for the two decode read ports.
module rf_writeback_arbiter
   import rf_writeback_arbiter_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int LINK_REG   = LINK_REG_DEF,
   parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
   input logic                  clk,
   input logic                  reset,
   rf_writeback_arbiter_if.slave bus
);

   localparam logic [ADDR_W-1:0]     LINK_ADDR = ADDR_W'(LINK_REG);
   localparam logic [ADDR_W-1:0]     ZERO_ADDR = {ADDR_W{1'b0}};
   localparam logic [DROP_CNT_W-1:0] DROP_ONE  = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

   grant_t                rr_gnt_s;
   grant_t                grant_s;
   logic [ADDR_W-1:0]     win_addr_s;
   logic [DATA_W-1:0]     win_data_s;
   logic                  wb_valid_s;

   rr_state_t             rr_r;
   logic                  rf_we_r;
   logic [ADDR_W-1:0]     rf_waddr_r;
   logic [DATA_W-1:0]     rf_wdata_r;
   logic [DROP_CNT_W-1:0] drop_r;

   // Winner selection: link first, then the round-robin pick between ALU and mem.
   always_comb begin
      rr_gnt_s = (rr_r == PREFER_ALU) ? GNT_ALU : GNT_MEM;
      grant_s  = GNT_NONE;
      if (reset) begin
         grant_s = GNT_NONE;
      end else if (bus.link_valid) begin
         grant_s = GNT_LINK;
      end else if (bus.alu_valid && bus.mem_valid) begin
         grant_s = rr_gnt_s;
      end else if (bus.alu_valid) begin
         grant_s = GNT_ALU;
      end else if (bus.mem_valid) begin
         grant_s = GNT_MEM;
      end else begin
         grant_s = GNT_NONE;
      end
   end

   // Address/data mux for the granted requester.
   always_comb begin
      win_addr_s = ZERO_ADDR;
      win_data_s = {DATA_W{1'b0}};
      case (grant_s)
         GNT_LINK: begin
            win_addr_s = LINK_ADDR;
            win_data_s = bus.link_pc;
         end
         GNT_ALU: begin
            win_addr_s = bus.alu_addr;
            win_data_s = bus.alu_data;
         end
         GNT_MEM: begin
            win_addr_s = bus.mem_addr;
            win_data_s = bus.mem_data;
         end
         default: begin
            win_addr_s = ZERO_ADDR;
            win_data_s = {DATA_W{1'b0}};
         end
      endcase
   end

   // Round-robin FSM and registered write port; register-0 writes are consumed and counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_r       <= PREFER_ALU;
         rf_we_r    <= 1'b0;
         rf_waddr_r <= ZERO_ADDR;
         rf_wdata_r <= {DATA_W{1'b0}};
         drop_r     <= {DROP_CNT_W{1'b0}};
      end else begin
         rr_r <= rr_next(rr_r, grant_s);
         if (grant_s == GNT_NONE) begin
            rf_we_r <= 1'b0;
         end else if (win_addr_s == ZERO_ADDR) begin
            rf_we_r <= 1'b0;
            if (!(&drop_r)) begin
               drop_r <= drop_r + DROP_ONE;
            end
         end else begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= win_addr_s;
            rf_wdata_r <= win_data_s;
         end
      end
   end

   assign bus.link_ready = (grant_s == GNT_LINK);
   assign bus.alu_ready  = (grant_s == GNT_ALU);
   assign bus.mem_ready  = (grant_s == GNT_MEM);
   assign bus.rf_we      = rf_we_r;
   assign bus.rf_waddr   = rf_waddr_r;
   assign bus.rf_wdata   = rf_wdata_r;
   assign bus.drop_count = drop_r;

   // A write still sitting in the output stage is discarded by reset, so it cannot stall decode.
   assign wb_valid_s = rf_we_r & ~reset;

   rf_hazard_check #(.ADDR_W(ADDR_W), .LINK_REG(LINK_REG)) u_hazard_a (
      .rd_addr    (bus.rd_addr_a),
      .wb_valid   (wb_valid_s),
      .wb_addr    (rf_waddr_r),
      .alu_valid  (bus.alu_valid),
      .alu_addr   (bus.alu_addr),
      .mem_valid  (bus.mem_valid),
      .mem_addr   (bus.mem_addr),
      .link_valid (bus.link_valid),
      .hazard     (bus.hazard_a)
   );

   rf_hazard_check #(.ADDR_W(ADDR_W), .LINK_REG(LINK_REG)) u_hazard_b (
      .rd_addr    (bus.rd_addr_b),
      .wb_valid   (wb_valid_s),
      .wb_addr    (rf_waddr_r),
      .alu_valid  (bus.alu_valid),
      .alu_addr   (bus.alu_addr),
      .mem_valid  (bus.mem_valid),
      .mem_addr   (bus.mem_addr),
      .link_valid (bus.link_valid),
      .hazard     (bus.hazard_b)
   );

endmodule
